// File: rtl/accel_pkg.sv
// Shared accelerator definitions: obuf geometry, lane width derivation and
// the drain engine state encoding.
package accel_pkg;

  localparam int LOG_DEPTH = 5;

  // Per-lane psum width grows with the reduction depth of the array.
  function automatic int col_width(input int log_array_size);
    return 10 + log_array_size;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    FINISH
  } drain_state_t;

endpackage

// File: rtl/obuf_drain.sv
// Output-buffer readback: strobes one obuf row per read_o, then serializes
// its columns as one beat per handshake toward the host.
module obuf_drain
  import accel_pkg::*;
#(
  parameter int ARRAY_SIZE     = 8,
  parameter int LOG_ARRAY_SIZE = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [LOG_DEPTH:0]                     num_rows,
  output logic                                   read_o,
  input  logic [ARRAY_SIZE*col_width(LOG_ARRAY_SIZE)*4-1:0] obuf_out,
  output logic [col_width(LOG_ARRAY_SIZE)*4-1:0] out_data,
  output logic [LOG_ARRAY_SIZE-1:0]              out_col,
  output logic                                   out_valid,
  output logic                                   out_last,
  input  logic                                   out_ready,
  output logic                                   busy,
  output logic                                   done
);

  localparam int BEAT_W = col_width(LOG_ARRAY_SIZE) * 4;
  localparam logic [LOG_ARRAY_SIZE-1:0] COL_LAST = LOG_ARRAY_SIZE'(ARRAY_SIZE - 1);

  drain_state_t state, state_nx;
  logic [LOG_DEPTH:0]                   rows_left;
  logic [LOG_ARRAY_SIZE-1:0]            col;
  logic [ARRAY_SIZE-1:0][BEAT_W-1:0]    row;
  logic                                 hs;

  assign hs = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rows_left <= '0;
      col       <= '0;
      row       <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) rows_left <= num_rows;
        WAIT: begin
          // obuf data is valid the cycle after the strobe
          row       <= obuf_out;
          col       <= '0;
          rows_left <= rows_left - 1'b1;
        end
        SEND: if (hs && col != COL_LAST) col <= col + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    read_o    = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nx = (num_rows != '0) ? READ : FINISH;
      READ: begin
        read_o   = 1'b1;
        state_nx = WAIT;
      end
      WAIT: state_nx = SEND;
      SEND: begin
        out_valid = 1'b1;
        if (hs && col == COL_LAST) state_nx = (rows_left != '0) ? READ : FINISH;
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign out_data = row[col];
  assign out_col  = col;
  assign out_last = out_valid & (col == COL_LAST) & (rows_left == '0);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_obuf_drain.sv
// Randomized bench for obuf_drain: an obuf model feeds rows, and a
// job-level beat queue predicts every accepted beat, busy and done timing.
module tb_obuf_drain;
  localparam int AS = 8;
  localparam int BW = 52;
  localparam int RW = AS * BW;

  typedef struct packed {
    logic [BW-1:0] d;
    logic [2:0]    c;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [5:0]    num_rows = '0;
  logic          read_o;
  logic [RW-1:0] obuf_out = '0;
  logic [BW-1:0] out_data;
  logic [2:0]    out_col;
  logic          out_valid, out_last, busy, done;
  logic          out_ready = 1'b1;

  obuf_drain dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .read_o(read_o),
    .obuf_out(obuf_out), .out_data(out_data), .out_col(out_col),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // accelerator side: row memory with an auto-incrementing read address
  logic [RW-1:0] mem [32];
  logic [4:0]    acc_addr = '0;
  always @(posedge clk)
    if (read_o) begin
      obuf_out <= mem[acc_addr];
      acc_addr <= acc_addr + 5'd1;
    end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model state
  beat_t exp_q[$];
  beat_t hs_q[$];
  int    rd_q[$];
  logic  mbusy = 1'b0;
  logic [4:0] maddr = '0;
  int    job_rows = 0, start_cyc = 0, done_cyc = 0, last_hs = 0, ndone = 0;
  logic  stall = 1'b0;
  logic [BW+3:0] prev_out = '0;

  always @(negedge clk) begin
    beat_t b, e;
    logic  mbusy_nx;
    if (rst_q) begin
      chk("rst_ctrl", {read_o, out_valid, out_last, busy, done, out_col}, 64'd0);
      chk("rst_data", out_data, 64'd0);
      exp_q.delete();
      mbusy = 1'b0;
      maddr = acc_addr;
      stall = 1'b0;
    end else begin
      mbusy_nx = mbusy;
      chk("busy", busy, mbusy);
      if (read_o) begin
        rd_q.push_back(cyc);
        if (out_valid) chk("read_during_valid", 1, 0);
      end
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", {out_data, out_col, out_last}, prev_out);
      end
      if (out_valid && out_ready) begin
        b = '{d: out_data, c: out_col, l: out_last};
        hs_q.push_back(b);
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat_data", b.d, e.d);
          chk("beat_col", b.c, e.c);
          chk("beat_last", b.l, e.l);
          if (e.l) last_hs = cyc;
        end
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
        chk("done_beats_left", exp_q.size(), 0);
        if (job_rows == 0) chk("done_empty_time", done_cyc - start_cyc, 1);
        else chk("done_after_last", done_cyc - last_hs, 1);
        mbusy_nx = 1'b0;
      end
      if (start && !mbusy) begin
        job_rows  = int'(num_rows);
        start_cyc = cyc;
        for (int r = 0; r < job_rows; r++)
          for (int c = 0; c < AS; c++) begin
            e.d = mem[5'(maddr + 5'(r))][c*BW +: BW];
            e.c = 3'(c);
            e.l = (r == job_rows - 1) && (c == AS - 1);
            exp_q.push_back(e);
          end
        maddr = maddr + 5'(job_rows);
        mbusy_nx = 1'b1;
      end
      stall    = out_valid && !out_ready;
      prev_out = {out_data, out_col, out_last};
      mbusy    = mbusy_nx;
    end
  end

  int rdy_mode = 0;
  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic fill_mem();
    for (int a = 0; a < 32; a++)
      for (int w = 0; w < RW / 32 + 1; w++)
        if (w * 32 < RW) mem[a][w*32 +: 32] = $urandom;
  endtask

  task automatic wait_done(input int nd0, input int bound);
    for (int i = 0; i < bound && ndone == nd0; i++) @(posedge clk);
    if (ndone == nd0) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_job(input int r, input int bound, input bool_extra);
    int nd0;
    hs_q.delete(); rd_q.delete();
    nd0 = ndone;
    @(posedge clk); #1; start = 1'b1; num_rows = 6'(r);
    @(posedge clk); #1; start = 1'b0;
    if (bool_extra) begin
      repeat ($urandom_range(1, 12)) @(posedge clk);
      #1; start = 1'b1; num_rows = 6'd5;
      @(posedge clk); #1; start = 1'b0;
    end
    wait_done(nd0, bound);
  endtask

  initial begin
    int nd0;
    logic [RW-1:0] row1;
    fill_mem();
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;

    // single row with columns 1..8
    for (int c = 0; c < AS; c++) row1[c*BW +: BW] = BW'(c + 1);
    mem[acc_addr] = row1;
    run_job(1, 100, 0);
    chk("t1_reads", rd_q.size(), 1);
    chk("t1_beats", hs_q.size(), 8);
    for (int c = 0; c < hs_q.size(); c++) begin
      chk("t1_data", hs_q[c].d, 64'(c + 1));
      chk("t1_col", hs_q[c].c, 64'(c));
      chk("t1_last", hs_q[c].l, (c == 7) ? 64'd1 : 64'd0);
    end
    chk("t1_done_time", done_cyc - start_cyc, 11);
    if (rd_q.size() > 0) chk("t1_read_time", rd_q[0] - start_cyc, 1);

    // three rows back to back
    fill_mem();
    run_job(3, 200, 0);
    chk("t2_beats", hs_q.size(), 24);
    chk("t2_reads", rd_q.size(), 3);
    if (rd_q.size() == 3) begin
      chk("t2_rd_gap0", rd_q[1] - rd_q[0], 10);
      chk("t2_rd_gap1", rd_q[2] - rd_q[1], 10);
    end
    chk("t2_done_time", done_cyc - start_cyc, 31);

    // alternating backpressure, ready low on the first SEND cycle
    hs_q.delete(); rd_q.delete();
    nd0 = ndone;
    @(posedge clk); #1; start = 1'b1; num_rows = 6'd1;
    for (int j = 1; j < 60 && ndone == nd0; j++) begin
      @(posedge clk); #1; start = 1'b0;
      out_ready = (j % 2 == 0);
    end
    if (ndone == nd0) chk("t3_done_timeout", 0, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_beats", hs_q.size(), 8);
    chk("t3_done_time", done_cyc - start_cyc, 19);

    // empty job
    run_job(0, 20, 0);
    chk("t4_reads", rd_q.size(), 0);
    chk("t4_beats", hs_q.size(), 0);
    chk("t4_done_time", done_cyc - start_cyc, 1);

    // start pulsed again mid-job
    run_job(2, 200, 1);
    chk("t5_beats", hs_q.size(), 16);
    chk("t5_reads", rd_q.size(), 2);

    // reset while sending column 3
    @(posedge clk); #1; start = 1'b1; num_rows = 6'd2;
    @(posedge clk); #1; start = 1'b0;
    begin
      int k = 0;
      while (k < 50 && !(out_valid && out_col == 3)) begin @(negedge clk); k++; end
      if (k == 50) chk("t6_col3_timeout", 0, 1);
    end
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("t6_after_rst", {out_valid, busy, read_o}, 64'd0);
    mem[acc_addr] = row1;
    run_job(1, 100, 0);
    chk("t6_beats", hs_q.size(), 8);
    chk("t6_done_time", done_cyc - start_cyc, 11);

    // randomized jobs with random backpressure
    rdy_mode = 1;
    for (int n = 0; n < 12; n++) begin
      fill_mem();
      run_job($urandom_range(0, 6), 600, ($urandom_range(0, 2) == 0));
    end
    rdy_mode = 0;
    out_ready = 1'b1;

    // full-depth drain
    fill_mem();
    run_job(32, 1000, 0);
    chk("t8_reads", rd_q.size(), 32);
    chk("t8_beats", hs_q.size(), 256);
    chk("t8_done_time", done_cyc - start_cyc, 321);
    chk("final_addr", acc_addr, maddr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
